rv_mem_arbiter: RTL

RV_MEM_ARBITER -- requirements
Module: rv_mem_arbiter

---
 rtl/rv_mem_arbiter_if.sv | 56 +++++
 rtl/rv_mem_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/rv_mem_arbiter_if.sv
// Bus bundle for rv_mem_arbiter: fetch and load/store requester channels, memory channel, grant/busy status.
// slave = arbiter side; master = requesters plus memory.
interface rv_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_addr_vld;
   logic [ADDR_W-1:0] if_addr;
   logic              if_addr_rsp;
   logic              if_data_vld;
   logic [DATA_W-1:0] if_rdata;
   logic              if_data_rsp;

   logic              ls_addr_vld;
   logic [ADDR_W-1:0] ls_addr;
   logic              ls_op;
   logic [1:0]        ls_size;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_addr_rsp;
   logic              ls_data_vld;
   logic [DATA_W-1:0] ls_rdata;
   logic              ls_data_rsp;

   logic              mem_addr_vld;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_op;
   logic [1:0]        mem_size;
   logic              mem_addr_rsp;
   logic              mem_wdata_vld;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_data_rsp;

   logic [1:0]        grant;
   logic              busy;

   modport slave (
      input  if_addr_vld, if_addr, if_data_vld,
      input  ls_addr_vld, ls_addr, ls_op, ls_size, ls_wdata, ls_data_vld,
      input  mem_addr_rsp, mem_rdata, mem_data_rsp,
      output if_addr_rsp, if_rdata, if_data_rsp,
      output ls_addr_rsp, ls_rdata, ls_data_rsp,
      output mem_addr_vld, mem_addr, mem_op, mem_size, mem_wdata_vld, mem_wdata,
      output grant, busy
   );

   modport master (
      output if_addr_vld, if_addr, if_data_vld,
      output ls_addr_vld, ls_addr, ls_op, ls_size, ls_wdata, ls_data_vld,
      output mem_addr_rsp, mem_rdata, mem_data_rsp,
      input  if_addr_rsp, if_rdata, if_data_rsp,
      input  ls_addr_rsp, ls_rdata, ls_data_rsp,
      input  mem_addr_vld, mem_addr, mem_op, mem_size, mem_wdata_vld, mem_wdata,
      input  grant, busy
   );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single split address/data memory port.
// Optional macro RV_MEM_ARB_RR_EN: round-robin tie break; otherwise load/store wins ties.
module rv_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic           clk,
   input logic           rst,
   rv_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        grant_q;
   logic [ADDR_W-1:0] cap_addr;
   logic              cap_op;
   logic [1:0]        cap_size;
   logic [DATA_W-1:0] cap_wdata;

   logic pick_if;
   logic pick_ls;
   logic start;
   logic owner_dvld;
   logic addr_done;
   logic data_done;

`ifdef RV_MEM_ARB_RR_EN
   // last_ls resets high so the first tie goes to fetch.
   logic last_ls;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_ls <= 1'b1;
      else if (start)
         last_ls <= pick_ls;
   end

   always_comb begin
      pick_ls = bus.ls_addr_vld & (~bus.if_addr_vld | ~last_ls);
      pick_if = bus.if_addr_vld & ~pick_ls;
   end
`else
   always_comb begin
      pick_ls = bus.ls_addr_vld;
      pick_if = bus.if_addr_vld & ~bus.ls_addr_vld;
   end
`endif

   always_comb begin
      start      = (state == IDLE) & (pick_if | pick_ls);
      owner_dvld = (grant_q[0] & bus.if_data_vld) | (grant_q[1] & bus.ls_data_vld);
      addr_done  = (state == ADDR) & bus.mem_addr_rsp;
      data_done  = (state == DATA) & owner_dvld & bus.mem_data_rsp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = ADDR;
         ADDR:    if (addr_done) state_nxt = DATA;
         DATA:    if (data_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant and captured request fields change only at the IDLE->ADDR transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q   <= '0;
         cap_addr  <= '0;
         cap_op    <= 1'b0;
         cap_size  <= '0;
         cap_wdata <= '0;
      end else if (start) begin
         grant_q <= {pick_ls, pick_if};
         if (pick_ls) begin
            cap_addr  <= bus.ls_addr;
            cap_op    <= bus.ls_op;
            cap_size  <= bus.ls_size;
            cap_wdata <= bus.ls_wdata;
         end else begin
            cap_addr  <= bus.if_addr;
            cap_op    <= 1'b0;
            cap_size  <= 2'd2;
            cap_wdata <= '0;
         end
      end else if (data_done) begin
         grant_q <= '0;
      end
   end

   always_comb begin
      bus.mem_addr_vld  = (state == ADDR);
      bus.mem_addr      = cap_addr;
      bus.mem_op        = cap_op;
      bus.mem_size      = cap_size;
      bus.mem_wdata     = cap_wdata;
      bus.mem_wdata_vld = (state == DATA) & owner_dvld;
      bus.if_addr_rsp   = addr_done & grant_q[0];
      bus.ls_addr_rsp   = addr_done & grant_q[1];
      bus.if_data_rsp   = data_done & grant_q[0];
      bus.ls_data_rsp   = data_done & grant_q[1];
      bus.if_rdata      = bus.mem_rdata;
      bus.ls_rdata      = bus.mem_rdata;
      bus.grant         = grant_q;
      bus.busy          = (state != IDLE);
   end
endmodule
